// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Issue controller between decode and the even/odd execution pipes of a
//   dual-issue core. Holds one fetched instruction pair, tracks in-flight
//   destinations in a per-register latency scoreboard, and issues slot0/slot1
//   in program order. It stalls on RAW, WAW and pipe-conflict hazards. A taken
//   branch (flush) discards whatever is buffered.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   fetch_valid / fetch_ready  pair handshake from decode
//   s0_* / s1_*                slot0 (older) / slot1 (younger) instruction fields:
//                              instr, pipe (0 even / 1 odd), ra/rb/rc sources,
//                              use {ra,rb,rc} read-enables, rt destination,
//                              wr writes rt, lat result latency
//   s1_valid                   slot1 holds a real instruction
//   flush                      branch taken; drop the buffer
//   even_valid/even_instr      registered even-pipe issue
//   odd_valid/odd_instr        registered odd-pipe issue
//   stall_cnt, dual_cnt        issue statistics
//
// Configuration macro: ISSUE_STATS_EN
//   Defined   -> stall_cnt / dual_cnt are 32-bit wrapping counters.
//   Undefined -> both outputs are tied to 0 and no counter logic exists.
module dual_issue_scheduler #(
  parameter  int IW    = 32,
  parameter  int NREG  = 128,
  parameter  int LAT_W = 3,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [IW-1:0]    s0_instr,
  input  logic [IW-1:0]    s1_instr,
  input  logic             s1_valid,
  input  logic             s0_pipe,
  input  logic             s1_pipe,
  input  logic [RW-1:0]    s0_ra,
  input  logic [RW-1:0]    s0_rb,
  input  logic [RW-1:0]    s0_rc,
  input  logic [RW-1:0]    s1_ra,
  input  logic [RW-1:0]    s1_rb,
  input  logic [RW-1:0]    s1_rc,
  input  logic [2:0]       s0_use,
  input  logic [2:0]       s1_use,
  input  logic [RW-1:0]    s0_rt,
  input  logic [RW-1:0]    s1_rt,
  input  logic             s0_wr,
  input  logic             s1_wr,
  input  logic [LAT_W-1:0] s0_lat,
  input  logic [LAT_W-1:0] s1_lat,
  input  logic             flush,
  output logic             even_valid,
  output logic [IW-1:0]    even_instr,
  output logic             odd_valid,
  output logic [IW-1:0]    odd_instr,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      dual_cnt
);

  typedef struct packed {
    logic [IW-1:0]    instr;
    logic             pipe;
    logic [RW-1:0]    ra;
    logic [RW-1:0]    rb;
    logic [RW-1:0]    rc;
    logic [2:0]       use_en;
    logic [RW-1:0]    rt;
    logic             wr;
    logic [LAT_W-1:0] lat;
  } slot_t;

  typedef enum logic [1:0] {EMPTY, PAIR, ONE1} state_t;

  state_t                       state;
  slot_t                        b0, b1;   // b1 also holds the lone pending op in ONE1
  slot_t                        in0, in1;
  logic [NREG-1:0][LAT_W-1:0]   sb, sb_n;
  logic                         rdy0, rdy1, pair_ok;
  logic                         iss0, iss1, drain, accept;
  logic                         ev_n, ov_n;
  logic [IW-1:0]                ei_n, oi_n;

  assign in0 = '{s0_instr, s0_pipe, s0_ra, s0_rb, s0_rc, s0_use, s0_rt, s0_wr, s0_lat};
  assign in1 = '{s1_instr, s1_pipe, s1_ra, s1_rb, s1_rc, s1_use, s1_rt, s1_wr, s1_lat};

  // Sources must have no result in flight; a writer may not finish before an
  // older in-flight write to the same register (WAW).
  function automatic logic slot_ready(input slot_t s, input logic [LAT_W-1:0] va,
                                      input logic [LAT_W-1:0] vb, input logic [LAT_W-1:0] vc,
                                      input logic [LAT_W-1:0] vt);
    return !(s.use_en[2] && va != '0) && !(s.use_en[1] && vb != '0) &&
           !(s.use_en[0] && vc != '0) && !(s.wr && vt > s.lat);
  endfunction

  always_comb begin
    rdy0    = slot_ready(b0, sb[b0.ra], sb[b0.rb], sb[b0.rc], sb[b0.rt]);
    rdy1    = slot_ready(b1, sb[b1.ra], sb[b1.rb], sb[b1.rc], sb[b1.rt]);
    // Intra-pair hazards the scoreboard cannot see yet: s0's write is not
    // recorded until after this cycle.
    pair_ok = (b1.pipe != b0.pipe) &&
              !(b0.wr && ((b1.use_en[2] && b1.ra == b0.rt) ||
                          (b1.use_en[1] && b1.rb == b0.rt) ||
                          (b1.use_en[0] && b1.rc == b0.rt))) &&
              !(b0.wr && b1.wr && b1.rt == b0.rt);
    iss0 = 1'b0;
    iss1 = 1'b0;
    if (!flush) begin
      case (state)
        PAIR: begin
          iss0 = rdy0;
          iss1 = rdy0 && pair_ok && rdy1;
        end
        ONE1:    iss1 = rdy1;
        default: ;
      endcase
    end
  end

  assign drain       = (state == PAIR && iss0 && iss1) || (state == ONE1 && iss1);
  assign fetch_ready = !flush && (state == EMPTY || drain);
  assign accept      = fetch_valid && fetch_ready;

  // Route each issued op to the port named by its pipe bit; a dual issue
  // always has differing pipe bits, so the two never collide.
  always_comb begin
    ev_n = (iss0 && !b0.pipe) || (iss1 && !b1.pipe);
    ov_n = (iss0 &&  b0.pipe) || (iss1 &&  b1.pipe);
    ei_n = (iss0 && !b0.pipe) ? b0.instr : (iss1 && !b1.pipe) ? b1.instr : '0;
    oi_n = (iss0 &&  b0.pipe) ? b0.instr : (iss1 &&  b1.pipe) ? b1.instr : '0;
  end

  // Countdown per register; an issuing writer overrides the decrement of its
  // own entry. The max keeps a longer older write visible.
  always_comb begin
    for (int i = 0; i < NREG; i++)
      sb_n[i] = (sb[i] != '0) ? sb[i] - LAT_W'(1) : '0;
    if (iss0 && b0.wr) sb_n[b0.rt] = (b0.lat > sb_n[b0.rt]) ? b0.lat : sb_n[b0.rt];
    if (iss1 && b1.wr) sb_n[b1.rt] = (b1.lat > sb_n[b1.rt]) ? b1.lat : sb_n[b1.rt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      b0    <= '0;
      b1    <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (accept) begin
      b0    <= in0;
      b1    <= s1_valid ? in1 : in0;
      state <= s1_valid ? PAIR : ONE1;
    end else begin
      case (state)
        PAIR:    if (iss0) state <= iss1 ? EMPTY : ONE1;
        ONE1:    if (iss1) state <= EMPTY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb         <= '0;
      even_valid <= 1'b0;
      even_instr <= '0;
      odd_valid  <= 1'b0;
      odd_instr  <= '0;
    end else begin
      sb         <= sb_n;
      even_valid <= ev_n;
      even_instr <= ei_n;
      odd_valid  <= ov_n;
      odd_instr  <= oi_n;
    end
  end

`ifdef ISSUE_STATS_EN
  logic [31:0] stall_q, dual_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      dual_q  <= '0;
    end else begin
      if (state != EMPTY && !iss0 && !iss1) stall_q <= stall_q + 32'd1;
      if (iss0 && iss1)                     dual_q  <= dual_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign dual_cnt  = dual_q;
`else
  assign stall_cnt = '0;
  assign dual_cnt  = '0;
`endif

endmodule
